dcache_ctrl_fsm_p: RTL and testbench
====================================

// Module: dcache_ctrl_fsm_p
// PURPOSE
//   Parametrised main control FSM for the data cache; successor to the fixed 4-way/64-byte controller.
//   Sits between the request buffer / tag-compare datapath and the AXI bridge.
//   Adds three things over the previous controller:
//   - NWAY-way, LINE_BYTES-line generalisation;
//   - dirty-victim writeback on ANY miss (read or write), not only on write misses;
//   - uncached read and uncached write paths, plus saturating hit/miss performance counters.
// PARAMETERS
//   NWAY        4   associativity; width of all one-hot way vectors
//   LINE_BYTES  64  bytes per line; width of byte write-enable vectors
//   PERF_W      32  width of each performance counter
// PORTS
//   clk             in   1           clock
//   rst             in   1           synchronous reset, active-high
//   valid           in   1           CPU request present
//   op              in   1           0=READ 1=WRITE (from request buffer, stable until done)
//   uncached        in   1           request is uncached (from request buffer, stable until done)
//   cache_hit       in   1           tag hit, LOOKUP only
//   hit             in   NWAY        one-hot hit way
//   lru_way_sel     in   NWAY        one-hot victim way
//   victim_vld      in   1           victim line valid
//   victim_dirty    in   1           victim line dirty
//   byte_we_normal  in   LINE_BYTES  store byte enables for a hit
//   r_rdy           in   1           AXI read request accepted
//   w_rdy           in   1           AXI write request accepted
//   fill_finish     in   1           last read beat received (line, or single uncached beat)
//   wrt_finish      in   1           AXI write response received
//   way_visit, mem_en, tagv_we, dirty_we   out  NWAY        one-hot way controls
//   mem_we          out  LINE_BYTES  data RAM byte enables
//   mbuf_we, rbuf_we, pbuf_we, wbuf_we, wbuf_reset, way_sel_en   out  1   buffer/datapath strobes
//   rdata_sel, wrt_data_sel, w_dirty_data                        out  1   datapath selects
//   r_req, w_req    out  1  AXI requests, held until rdy
//   r_data_ready    out  1  AXI read data ready
//   req_uncached    out  1  qualifies r_req/w_req as single-beat uncached
//   data_valid      out  1  response to CPU
//   cache_ready     out  1  can accept a new request this cycle
//   hit_cnt, miss_cnt  out  PERF_W  saturating counters
// BEHAVIOUR
//   - State register, wb_pend flag and counters are synchronous. All other outputs decode combinationally
//     from state and inputs; every output defaults to 0.
//   - rst forces IDLE, wb_pend=0, hit_cnt=miss_cnt=0, regardless of state (mid-refill reset is legal).
//     Reset outputs are the IDLE values: rbuf_we=1, cache_ready=1, everything else 0.
//   - State transitions:
//     - IDLE: valid -> LOOKUP.
//     - LOOKUP, uncached=1 (hit ignored): op=READ -> UCR_REQ; op=WRITE -> UCW_REQ.
//     - LOOKUP, hit: valid ? LOOKUP : IDLE (back-to-back hits, 1 cycle each).
//     - LOOKUP, miss: victim_vld&victim_dirty -> WB_REQ, else RF_REQ.
//     - WB_REQ: w_req=1; w_rdy -> RF_REQ and set wb_pend.
//     - RF_REQ: r_req=1; r_rdy -> REFILL.
//     - REFILL: r_data_ready=1; fill_finish -> WAIT_WB.
//     - WAIT_WB: done when !wb_pend. On done: valid ? LOOKUP : IDLE.
//     - UCR_REQ: r_req=1, req_uncached=1; r_rdy -> UCR_WAIT.
//     - UCR_WAIT: r_data_ready=1; fill_finish -> done.
//     - UCW_REQ: w_req=1, req_uncached=1; w_rdy -> UCW_WAIT.
//     - UCW_WAIT: wrt_finish -> done.
//   - wb_pend: cleared by wrt_finish in any state. wrt_finish arriving during REFILL clears it early,
//     so WAIT_WB completes in its first cycle. Set and clear in the same cycle: set wins.
//   - Done cycle (WAIT_WB / UCR_WAIT / UCW_WAIT): data_valid=1, rbuf_we=1, cache_ready=1;
//     wbuf_reset=1 for WAIT_WB only.
//   - LOOKUP: rdata_sel=wrt_data_sel=pbuf_we=1.
//     - Cached miss adds mbuf_we=wbuf_we=1.
//     - Cached hit adds data_valid=rbuf_we=cache_ready=way_sel_en=1 and way_visit=hit.
//     - Cached write hit also drives mem_en=hit, mem_we=byte_we_normal, dirty_we=hit, w_dirty_data=1.
//   - REFILL & fill_finish:
//     - mem_we=all ones; mem_en=tagv_we=dirty_we=way_visit=lru_way_sel; way_sel_en=1.
//     - w_dirty_data=op (a write miss lands dirty).
//   - Uncached accesses never touch tag/data/dirty RAM and never count in hit_cnt or miss_cnt.
//   - Counters, LOOKUP & !uncached only: cache_hit -> hit_cnt+1, else miss_cnt+1.
//     Each counter saturates at 2^PERF_W-1 and does not wrap.
//   - r_req/w_req never both high. A request drops only in the cycle after its rdy was sampled.
// STRUCTURE
//   - Package dcache_pkg: state localparams (4-bit, 10 states), OP_READ/OP_WRITE constants.
//   - Sub-module sat_counter #(PERF_W): inc -> saturating count. Instanced twice.
// TESTING
//   1. Reset, then valid=0 -> IDLE, rbuf_we=1, cache_ready=1, all other outputs 0, counters 0.
//   2. Read hit, hit=4'b0100, valid held 3 cycles -> data_valid 3 consecutive cycles,
//      way_visit=4'b0100, hit_cnt=3, mem_en=0.
//   3. Read miss, victim dirty+valid, lru=4'b0001; w_rdy delayed 2 cycles; wrt_finish during REFILL
//      -> w_req 3 cycles, then r_req; refill writes way 0 with w_dirty_data=0;
//      WAIT_WB done in 1 cycle; miss_cnt=1.
//   4. Write miss, clean victim -> no w_req; refill dirty_we=lru, w_dirty_data=1;
//      done with wbuf_reset=1.
//   5. Uncached write then uncached read -> req_uncached=1 on w_req then r_req;
//      tagv_we/mem_en stay 0; counters unchanged.
//   6. rst asserted in REFILL with wb_pend=1 -> next cycle IDLE, wb_pend=0,
//      r_data_ready=0; preload hit_cnt at max, then a hit -> hit_cnt stays at max.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types for the data-cache control path: controller state encoding and CPU op codes.
package dcache_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LOOKUP   = 4'd1,
    S_WB_REQ   = 4'd2,
    S_RF_REQ   = 4'd3,
    S_REFILL   = 4'd4,
    S_WAIT_WB  = 4'd5,
    S_UCR_REQ  = 4'd6,
    S_UCR_WAIT = 4'd7,
    S_UCW_REQ  = 4'd8,
    S_UCW_WAIT = 4'd9
  } state_e;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc and holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  output logic [PERF_W-1:0] count
);

  logic [PERF_W-1:0] count_q;
  logic [PERF_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {PERF_W{1'b1}})) begin
      count_d = count_q + {{(PERF_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/dcache_ctrl_fsm_p.sv
// Main data-cache control FSM: hit service, dirty-victim writeback, line refill, uncached access.
// Handshake: r_req/w_req stay high until the cycle their rdy is sampled; the state advances on that edge.
module dcache_ctrl_fsm_p
  import dcache_pkg::*;
#(
  parameter int NWAY       = 4,
  parameter int LINE_BYTES = 64,
  parameter int PERF_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic                  op,
  input  logic                  uncached,
  input  logic                  cache_hit,
  input  logic [NWAY-1:0]       hit,
  input  logic [NWAY-1:0]       lru_way_sel,
  input  logic                  victim_vld,
  input  logic                  victim_dirty,
  input  logic [LINE_BYTES-1:0] byte_we_normal,
  input  logic                  r_rdy,
  input  logic                  w_rdy,
  input  logic                  fill_finish,
  input  logic                  wrt_finish,
  output logic [NWAY-1:0]       way_visit,
  output logic [NWAY-1:0]       mem_en,
  output logic [NWAY-1:0]       tagv_we,
  output logic [NWAY-1:0]       dirty_we,
  output logic [LINE_BYTES-1:0] mem_we,
  output logic                  mbuf_we,
  output logic                  rbuf_we,
  output logic                  pbuf_we,
  output logic                  wbuf_we,
  output logic                  wbuf_reset,
  output logic                  way_sel_en,
  output logic                  rdata_sel,
  output logic                  wrt_data_sel,
  output logic                  w_dirty_data,
  output logic                  r_req,
  output logic                  w_req,
  output logic                  r_data_ready,
  output logic                  req_uncached,
  output logic                  data_valid,
  output logic                  cache_ready,
  output logic [PERF_W-1:0]     hit_cnt,
  output logic [PERF_W-1:0]     miss_cnt
);

  state_e state_q, state_d;
  logic   wb_pend_q, wb_pend_d;
  logic   done;
  logic   hit_inc, miss_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wb_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wb_pend_q <= wb_pend_d;
    end
  end

  // The victim writeback response may land any time after the request is accepted;
  // a new acceptance in the same cycle as a stale response must keep the flag set.
  always_comb begin
    wb_pend_d = wb_pend_q & ~wrt_finish;
    if ((state_q == S_WB_REQ) && w_rdy) begin
      wb_pend_d = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    way_visit    = '0;
    mem_en       = '0;
    tagv_we      = '0;
    dirty_we     = '0;
    mem_we       = '0;
    mbuf_we      = 1'b0;
    rbuf_we      = 1'b0;
    pbuf_we      = 1'b0;
    wbuf_we      = 1'b0;
    wbuf_reset   = 1'b0;
    way_sel_en   = 1'b0;
    rdata_sel    = 1'b0;
    wrt_data_sel = 1'b0;
    w_dirty_data = 1'b0;
    r_req        = 1'b0;
    w_req        = 1'b0;
    r_data_ready = 1'b0;
    req_uncached = 1'b0;
    data_valid   = 1'b0;
    cache_ready  = 1'b0;
    done         = 1'b0;
    hit_inc      = 1'b0;
    miss_inc     = 1'b0;

    case (state_q)
      S_IDLE: begin
        rbuf_we     = 1'b1;
        cache_ready = 1'b1;
        if (valid) state_d = S_LOOKUP;
      end

      S_LOOKUP: begin
        rdata_sel    = 1'b1;
        wrt_data_sel = 1'b1;
        pbuf_we      = 1'b1;
        if (uncached) begin
          state_d = (op == OP_WRITE) ? S_UCW_REQ : S_UCR_REQ;
        end else if (cache_hit) begin
          hit_inc     = 1'b1;
          data_valid  = 1'b1;
          rbuf_we     = 1'b1;
          cache_ready = 1'b1;
          way_sel_en  = 1'b1;
          way_visit   = hit;
          if (op == OP_WRITE) begin
            mem_en       = hit;
            mem_we       = byte_we_normal;
            dirty_we     = hit;
            w_dirty_data = 1'b1;
          end
          state_d = valid ? S_LOOKUP : S_IDLE;
        end else begin
          miss_inc = 1'b1;
          mbuf_we  = 1'b1;
          wbuf_we  = 1'b1;
          state_d  = (victim_vld && victim_dirty) ? S_WB_REQ : S_RF_REQ;
        end
      end

      S_WB_REQ: begin
        w_req = 1'b1;
        if (w_rdy) state_d = S_RF_REQ;
      end

      S_RF_REQ: begin
        r_req = 1'b1;
        if (r_rdy) state_d = S_REFILL;
      end

      S_REFILL: begin
        r_data_ready = 1'b1;
        if (fill_finish) begin
          // Whole line lands in the victim way; a write miss leaves it dirty.
          mem_we       = '1;
          mem_en       = lru_way_sel;
          tagv_we      = lru_way_sel;
          dirty_we     = lru_way_sel;
          way_visit    = lru_way_sel;
          way_sel_en   = 1'b1;
          w_dirty_data = op;
          state_d      = S_WAIT_WB;
        end
      end

      S_WAIT_WB: begin
        if (!wb_pend_q) begin
          done       = 1'b1;
          wbuf_reset = 1'b1;
        end
      end

      S_UCR_REQ: begin
        r_req        = 1'b1;
        req_uncached = 1'b1;
        if (r_rdy) state_d = S_UCR_WAIT;
      end

      S_UCR_WAIT: begin
        r_data_ready = 1'b1;
        if (fill_finish) done = 1'b1;
      end

      S_UCW_REQ: begin
        w_req        = 1'b1;
        req_uncached = 1'b1;
        if (w_rdy) state_d = S_UCW_WAIT;
      end

      S_UCW_WAIT: begin
        if (wrt_finish) done = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase

    if (done) begin
      data_valid  = 1'b1;
      rbuf_we     = 1'b1;
      cache_ready = 1'b1;
      state_d     = valid ? S_LOOKUP : S_IDLE;
    end
  end

  sat_counter #(.PERF_W(PERF_W)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc),
    .count (hit_cnt)
  );

  sat_counter #(.PERF_W(PERF_W)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc),
    .count (miss_cnt)
  );

endmodule

// File: tb/tb_dcache_ctrl_fsm_p.sv
// Bench for dcache_ctrl_fsm_p: directed scenarios plus randomized transactions checked
// against a transaction-level latency/strobe model; small PERF_W exposes saturation.
module tb_dcache_ctrl_fsm_p;

  localparam int NWAY = 4;
  localparam int LB   = 64;
  localparam int PW   = 4;
  localparam int MAXC = (1 << PW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic valid, op, uncached, cache_hit;
  logic [NWAY-1:0] hit, lru_way_sel;
  logic victim_vld, victim_dirty;
  logic [LB-1:0] byte_we_normal;
  logic r_rdy, w_rdy, fill_finish, wrt_finish;
  logic [NWAY-1:0] way_visit, mem_en, tagv_we, dirty_we;
  logic [LB-1:0] mem_we;
  logic mbuf_we, rbuf_we, pbuf_we, wbuf_we, wbuf_reset, way_sel_en;
  logic rdata_sel, wrt_data_sel, w_dirty_data;
  logic r_req, w_req, r_data_ready, req_uncached, data_valid, cache_ready;
  logic [PW-1:0] hit_cnt, miss_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int exp_hit = 0;
  int exp_miss = 0;

  always #5 clk = ~clk;

  dcache_ctrl_fsm_p #(.NWAY(NWAY), .LINE_BYTES(LB), .PERF_W(PW)) dut (
    .clk(clk), .rst(rst), .valid(valid), .op(op), .uncached(uncached),
    .cache_hit(cache_hit), .hit(hit), .lru_way_sel(lru_way_sel),
    .victim_vld(victim_vld), .victim_dirty(victim_dirty), .byte_we_normal(byte_we_normal),
    .r_rdy(r_rdy), .w_rdy(w_rdy), .fill_finish(fill_finish), .wrt_finish(wrt_finish),
    .way_visit(way_visit), .mem_en(mem_en), .tagv_we(tagv_we), .dirty_we(dirty_we),
    .mem_we(mem_we), .mbuf_we(mbuf_we), .rbuf_we(rbuf_we), .pbuf_we(pbuf_we),
    .wbuf_we(wbuf_we), .wbuf_reset(wbuf_reset), .way_sel_en(way_sel_en),
    .rdata_sel(rdata_sel), .wrt_data_sel(wrt_data_sel), .w_dirty_data(w_dirty_data),
    .r_req(r_req), .w_req(w_req), .r_data_ready(r_data_ready), .req_uncached(req_uncached),
    .data_valid(data_valid), .cache_ready(cache_ready), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  function automatic int sat_inc(input int v);
    return (v >= MAXC) ? v : v + 1;
  endfunction

  task automatic drive_quiet();
    valid = 1'b0; op = 1'b0; uncached = 1'b0; cache_hit = 1'b0;
    hit = '0; lru_way_sel = '0; victim_vld = 1'b0; victim_dirty = 1'b0;
    byte_we_normal = '0; r_rdy = 1'b0; w_rdy = 1'b0; fill_finish = 1'b0; wrt_finish = 1'b0;
  endtask

  // One CPU request from IDLE to completion; responder answers handshakes after given delays.
  task automatic run_txn(input string name, input bit unc, input bit op_i, input bit hit_i,
                         input bit vdirty, input logic [NWAY-1:0] way, input logic [LB-1:0] bwe,
                         input int w_dly, input int r_dly, input int f_dly, input int wf_dly);
    bit wb_need, cmiss, needs_r, needs_w, done_seen, lk_ok, dv_ready, dv_wbr, wdd;
    int f_cyc, w_cyc, d_cyc, exp_w, exp_r, exp_rdr, k;
    int cnt_w, cnt_r, cnt_f, w_acc, n_both, n_badu, n_tagv, n_memen, n_wbr, dv_cyc;
    int tagv_cyc, memen_cyc;
    logic [NWAY-1:0] tagv_seen, memen_seen;
    logic [LB-1:0] memwe_seen;

    cmiss   = !unc && !hit_i;
    wb_need = cmiss && vdirty;
    needs_w = wb_need || (unc && op_i);
    needs_r = unc ? !op_i : !hit_i;
    f_cyc = -1; w_cyc = -1;
    if (unc && op_i) begin
      w_cyc = 1 + w_dly + wf_dly; d_cyc = w_cyc;
    end else if (unc) begin
      f_cyc = 2 + r_dly + f_dly; d_cyc = f_cyc;
    end else if (hit_i) begin
      d_cyc = 0;
    end else if (wb_need) begin
      f_cyc = 3 + w_dly + r_dly + f_dly; w_cyc = 1 + w_dly + wf_dly;
      d_cyc = ((f_cyc > w_cyc) ? f_cyc : w_cyc) + 1;
    end else begin
      f_cyc = 2 + r_dly + f_dly; d_cyc = f_cyc + 1;
    end
    exp_w   = needs_w ? w_dly + 1 : 0;
    exp_r   = needs_r ? r_dly + 1 : 0;
    exp_rdr = needs_r ? f_dly + 1 : 0;
    if (!unc) begin
      if (hit_i) exp_hit = sat_inc(exp_hit);
      else       exp_miss = sat_inc(exp_miss);
    end

    @(negedge clk);
    drive_quiet();
    valid = 1'b1; op = op_i; uncached = unc;
    #1;
    n_cmp++;
    if (cache_ready !== 1'b1 || data_valid !== 1'b0)
      $display("FAIL %s idle_ready: cache_ready=%b data_valid=%b want 1/0", name, cache_ready, data_valid);
    if (cache_ready !== 1'b1 || data_valid !== 1'b0) n_err++;

    cnt_w = 0; cnt_r = 0; cnt_f = 0; w_acc = -100; n_both = 0; n_badu = 0;
    n_tagv = 0; n_memen = 0; n_wbr = 0; dv_cyc = -1; done_seen = 0; lk_ok = 0;
    tagv_cyc = -1; memen_cyc = -1; tagv_seen = '0; memen_seen = '0; memwe_seen = '0;
    wdd = 0; dv_ready = 0; dv_wbr = 0;

    for (int cyc = 0; cyc < 200 && !done_seen; cyc++) begin
      @(negedge clk);
      valid = 1'b0;
      if (cyc == 0) begin
        cache_hit = unc ? 1'($urandom_range(0, 1)) : hit_i;
        hit = (hit_i || unc) ? way : '0;
        lru_way_sel = hit_i ? {way[NWAY-2:0], way[NWAY-1]} : way;
        if (vdirty) begin
          victim_vld = 1'b1; victim_dirty = 1'b1;
        end else begin
          k = $urandom_range(0, 2);
          victim_vld = (k == 2); victim_dirty = (k == 1);
        end
        byte_we_normal = bwe;
      end
      w_rdy = 1'b0; r_rdy = 1'b0; fill_finish = 1'b0;
      wrt_finish = (w_cyc >= 0) && (cyc == w_acc + wf_dly);
      #1;
      if (w_req && cnt_w == w_dly) w_rdy = 1'b1;
      if (r_req && cnt_r == r_dly) r_rdy = 1'b1;
      if (r_data_ready && cnt_f == f_dly) fill_finish = 1'b1;
      #1;
      if (cyc == 0) lk_ok = pbuf_we && rdata_sel && wrt_data_sel &&
                            (!(hit_i && !unc) || (way_visit === way && way_sel_en));
      if (w_req) begin
        if (w_rdy) w_acc = cyc;
        cnt_w++;
      end
      if (r_req) cnt_r++;
      if (r_data_ready) cnt_f++;
      if (r_req && w_req) n_both++;
      if (req_uncached !== ((r_req || w_req) ? unc : 1'b0)) n_badu++;
      if (tagv_we !== '0) begin n_tagv++; tagv_seen = tagv_we; tagv_cyc = cyc; end
      if (mem_en !== '0) begin
        n_memen++; memen_seen = mem_en; memwe_seen = mem_we; memen_cyc = cyc; wdd = w_dirty_data;
      end
      if (wbuf_reset) n_wbr++;
      if (data_valid) begin
        done_seen = 1; dv_cyc = cyc; dv_ready = cache_ready; dv_wbr = wbuf_reset;
      end
    end

    n_cmp++;
    if (!done_seen || dv_cyc != d_cyc || !dv_ready) begin
      n_err++;
      $display("FAIL %s latency: done=%0d at cycle %0d ready=%b want cycle %0d ready=1", name, done_seen, dv_cyc, dv_ready, d_cyc);
    end
    n_cmp++;
    if (cnt_w != exp_w || cnt_r != exp_r || cnt_f != exp_rdr) begin
      n_err++;
      $display("FAIL %s req_cycles: w_req=%0d r_req=%0d r_data_ready=%0d want %0d/%0d/%0d", name, cnt_w, cnt_r, cnt_f, exp_w, exp_r, exp_rdr);
    end
    n_cmp++;
    if (n_both != 0 || n_badu != 0 || !lk_ok) begin
      n_err++;
      $display("FAIL %s qualifiers: both_req=%0d bad_uncached=%0d lookup_ok=%b want 0/0/1", name, n_both, n_badu, lk_ok);
    end
    n_cmp++;
    if (cmiss ? (n_tagv != 1 || tagv_seen !== way || tagv_cyc != f_cyc) : (n_tagv != 0)) begin
      n_err++;
      $display("FAIL %s tagv_we: count=%0d way=%b cycle=%0d want count=%0d way=%b cycle=%0d", name, n_tagv, tagv_seen, tagv_cyc, cmiss ? 1 : 0, way, f_cyc);
    end
    n_cmp++;
    if (cmiss) begin
      if (n_memen != 1 || memen_seen !== way || memwe_seen !== {LB{1'b1}} || memen_cyc != f_cyc || wdd !== op_i) begin
        n_err++;
        $display("FAIL %s refill_write: count=%0d mem_en=%b all_we=%b cycle=%0d w_dirty=%b want 1/%b/1/%0d/%b", name, n_memen, memen_seen, memwe_seen === {LB{1'b1}}, memen_cyc, wdd, way, f_cyc, op_i);
      end
    end else if (!unc && hit_i && op_i) begin
      if (n_memen != 1 || memen_seen !== way || memwe_seen !== bwe || memen_cyc != 0 || wdd !== 1'b1) begin
        n_err++;
        $display("FAIL %s store_hit: count=%0d mem_en=%b we_ok=%b cycle=%0d w_dirty=%b want 1/%b/1/0/1", name, n_memen, memen_seen, memwe_seen === bwe, memen_cyc, wdd, way);
      end
    end else if (n_memen != 0) begin
      n_err++;
      $display("FAIL %s mem_en_quiet: %0d cycles with mem_en, want 0", name, n_memen);
    end
    n_cmp++;
    if (cmiss ? (n_wbr != 1 || !dv_wbr) : (n_wbr != 0)) begin
      n_err++;
      $display("FAIL %s wbuf_reset: count=%0d at_done=%b want %0d", name, n_wbr, dv_wbr, cmiss ? 1 : 0);
    end

    @(negedge clk);
    drive_quiet();
    #1;
    n_cmp++;
    if (hit_cnt !== exp_hit[PW-1:0] || miss_cnt !== exp_miss[PW-1:0] || cache_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s counters: hit=%0d miss=%0d ready=%b want %0d/%0d/1", name, hit_cnt, miss_cnt, cache_ready, exp_hit, exp_miss);
    end
  endtask

  task automatic test_reset();
    drive_quiet();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_hit = 0; exp_miss = 0;
    @(negedge clk);
    #1;
    n_cmp++;
    if ({way_visit, mem_en, tagv_we, dirty_we, mem_we, mbuf_we, pbuf_we, wbuf_we, wbuf_reset,
         way_sel_en, rdata_sel, wrt_data_sel, w_dirty_data, r_req, w_req, r_data_ready,
         req_uncached, data_valid} !== '0) begin
      n_err++;
      $display("FAIL reset_quiet: way_visit=%b mem_en=%b tagv=%b r_req=%b w_req=%b dv=%b want all 0", way_visit, mem_en, tagv_we, r_req, w_req, data_valid);
    end
    n_cmp++;
    if (rbuf_we !== 1'b1 || cache_ready !== 1'b1 || hit_cnt !== '0 || miss_cnt !== '0) begin
      n_err++;
      $display("FAIL reset_idle: rbuf_we=%b cache_ready=%b hit=%0d miss=%0d want 1/1/0/0", rbuf_we, cache_ready, hit_cnt, miss_cnt);
    end
  endtask

  // Back-to-back read hits: valid held for n cycles gives n consecutive data_valid cycles.
  task automatic test_read_hit_b2b(input string name, input int n);
    int n_dv, n_bad;
    @(negedge clk);
    drive_quiet();
    valid = 1'b1;
    n_dv = 0; n_bad = 0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      valid = (c < n); cache_hit = 1'b1; hit = 4'b0100; lru_way_sel = 4'b0001;
      #1;
      if (data_valid) n_dv++;
      if (way_visit !== 4'b0100 || mem_en !== '0 || dirty_we !== '0) n_bad++;
      exp_hit = sat_inc(exp_hit);
    end
    @(negedge clk);
    drive_quiet();
    #1;
    n_cmp++;
    if (n_dv != n || n_bad != 0) begin
      n_err++;
      $display("FAIL %s hit_stream: data_valid=%0d bad_way_cycles=%0d want %0d/0", name, n_dv, n_bad, n);
    end
    n_cmp++;
    if (data_valid !== 1'b0 || cache_ready !== 1'b1 || hit_cnt !== exp_hit[PW-1:0] || miss_cnt !== exp_miss[PW-1:0]) begin
      n_err++;
      $display("FAIL %s hit_end: dv=%b ready=%b hit=%0d miss=%0d want 0/1/%0d/%0d", name, data_valid, cache_ready, hit_cnt, miss_cnt, exp_hit, exp_miss);
    end
  endtask

  task automatic test_dirty_read_miss();
    // w_rdy after two waits, response lands mid-REFILL so WAIT_WB finishes at once
    run_txn("dirty_read_miss", 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001, '0, 2, 0, 2, 3);
  endtask

  task automatic test_write_miss_clean();
    run_txn("clean_write_miss", 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000, '0, 0, 1, 1, 1);
  endtask

  task automatic test_uncached();
    run_txn("uncached_write", 1'b1, 1'b1, 1'b0, 1'b0, 4'b0010, '0, 1, 0, 0, 2);
    run_txn("uncached_read", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, '0, 0, 2, 1, 1);
  endtask

  task automatic test_reset_mid_refill();
    @(negedge clk);
    drive_quiet();
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0; lru_way_sel = 4'b0010; victim_vld = 1'b1; victim_dirty = 1'b1;
    @(negedge clk);
    w_rdy = 1'b1;
    @(negedge clk);
    w_rdy = 1'b0; r_rdy = 1'b1;
    @(negedge clk);
    r_rdy = 1'b0;
    #1;
    n_cmp++;
    if (r_data_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_refill_reach: r_data_ready=%b want 1", r_data_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_hit = 0; exp_miss = 0;
    #1;
    n_cmp++;
    if (r_data_ready !== 1'b0 || cache_ready !== 1'b1 || rbuf_we !== 1'b1 || hit_cnt !== '0 || miss_cnt !== '0) begin
      n_err++;
      $display("FAIL mid_refill_reset: rdr=%b ready=%b rbuf=%b hit=%0d miss=%0d want 0/1/1/0/0", r_data_ready, cache_ready, rbuf_we, hit_cnt, miss_cnt);
    end
    // A clean miss can only finish if the pending-writeback flag was cleared by reset.
    run_txn("post_reset_miss", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, '0, 0, 0, 0, 1);
    test_read_hit_b2b("saturate", MAXC + 3);
  endtask

  task automatic test_random(input int n);
    bit unc, op_i, hit_i, vd;
    logic [NWAY-1:0] way;
    logic [LB-1:0] bwe;
    for (int i = 0; i < n; i++) begin
      unc   = ($urandom_range(0, 3) == 0);
      op_i  = 1'($urandom_range(0, 1));
      hit_i = 1'($urandom_range(0, 1));
      vd    = 1'($urandom_range(0, 1));
      way   = NWAY'(1) << $urandom_range(0, NWAY - 1);
      bwe   = {$urandom, $urandom};
      run_txn($sformatf("rand%0d", i), unc, op_i, hit_i, vd, way, bwe,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, 8));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    drive_quiet();
    test_reset();
    test_read_hit_b2b("read_hit_b2b", 3);
    test_dirty_read_miss();
    test_write_miss_clean();
    test_uncached();
    test_random(30);
    test_reset_mid_refill();
    test_uncached();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
